// File: rtl/se_frame_streamer.sv
// Streams one frame from source memory into the SE block, then writes the SE output burst to result memory.
// Latency: start -> first read 1 cycle, first se_in_valid 3 cycles; result writes lag se_out_valid by 1 cycle.
// Backpressure: none downstream; pause only stalls read issue during STREAM, COLLECT aborts after TIMEOUT_CYCLES idle.
module se_frame_streamer #(
    parameter int DATA_WIDTH     = 16,
    parameter int IN_CHANNELS    = 16,
    parameter int IN_HEIGHT      = 56,
    parameter int IN_WIDTH       = 56,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] res_base_addr,
    input  logic                  pause,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] se_in_data,
    output logic                  se_in_valid,
    input  logic [DATA_WIDTH-1:0] se_out_data,
    input  logic                  se_out_valid,
    output logic                  res_wr_en,
    output logic [ADDR_WIDTH-1:0] res_wr_addr,
    output logic [DATA_WIDTH-1:0] res_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_early,
    output logic                  err_timeout
);

    localparam int TOTAL = IN_HEIGHT * IN_WIDTH * IN_CHANNELS;
    localparam int IW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ADDR_WIDTH:0] LAST_CNT  = (ADDR_WIDTH+1)'(TOTAL - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [IW-1:0]       IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0]       IDLE_ONE  = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] res_base_q;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic [ADDR_WIDTH:0]   wr_cnt;
    logic [IW-1:0]         idle_cnt;
    logic                  rd_vld_q;

    // Read issue is decoded from the registered state so a pause takes effect in the same cycle.
    assign mem_rd_en   = (state == S_STREAM) && !pause;
    assign mem_rd_addr = mem_rd_en ? (base_q + rd_cnt[ADDR_WIDTH-1:0]) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q    <= 1'b0;
            se_in_valid <= 1'b0;
            se_in_data  <= '0;
        end else begin
            rd_vld_q    <= mem_rd_en;
            se_in_valid <= rd_vld_q;
            if (rd_vld_q)
                se_in_data <= mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            base_q      <= '0;
            res_base_q  <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            idle_cnt    <= '0;
            res_wr_en   <= 1'b0;
            res_wr_addr <= '0;
            res_wr_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_early   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            res_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        res_base_q  <= res_base_addr;
                        rd_cnt      <= '0;
                        wr_cnt      <= '0;
                        idle_cnt    <= '0;
                        err_early   <= 1'b0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (se_out_valid)
                        err_early <= 1'b1;
                    if (!pause) begin
                        rd_cnt <= rd_cnt + CNT_ONE;
                        if (rd_cnt == LAST_CNT)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (se_out_valid)
                        err_early <= 1'b1;
                    state <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (se_out_valid) begin
                        res_wr_en   <= 1'b1;
                        res_wr_addr <= res_base_q + wr_cnt[ADDR_WIDTH-1:0];
                        res_wr_data <= se_out_data;
                        wr_cnt      <= wr_cnt + CNT_ONE;
                        idle_cnt    <= '0;
                        if (wr_cnt == LAST_CNT) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_ONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
